// File: rtl/esp32_boot_sequencer.sv
// ESP32 EN/GPIO0 sequencer: synchronises and glitch-filters the FTDI DTR/RTS auto-reset
// lines, then enforces the power-up hold, minimum reset width and bootloader strap timing.

module esp32_boot_sequencer #(
  parameter int C_powerup_cycles = 0,
  parameter int C_filter_cycles  = 250,
  parameter int C_reset_min      = 250000,
  parameter int C_strap_min      = 250000
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       ftdi_ndtr,
  input  logic       ftdi_nrts,
  input  logic       btn_reset,
  output logic       esp_en,
  output logic       esp_gpio0,
  output logic       boot_mode,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_POWERUP    = 3'd0,
    ST_RUN        = 3'd1,
    ST_RESET_HOLD = 3'd2,
    ST_STRAP      = 3'd3
  } state_t;

  localparam int MAX_A = (C_powerup_cycles > C_reset_min) ? C_powerup_cycles : C_reset_min;
  localparam int MAX_P = (MAX_A > C_strap_min) ? MAX_A : C_strap_min;
  localparam int CNT_W = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);
  localparam int FLT_N = (C_filter_cycles < 1) ? 1 : C_filter_cycles;
  localparam int FLT_W = $clog2(FLT_N + 1);

  // Reset and strap loads are one short so the state lasts exactly the minimum width.
  localparam logic [CNT_W-1:0] POWERUP_LOAD = CNT_W'(C_powerup_cycles);
  localparam logic [CNT_W-1:0] RESET_LOAD   = CNT_W'((C_reset_min > 0) ? C_reset_min - 1 : 0);
  localparam logic [CNT_W-1:0] STRAP_LOAD   = CNT_W'((C_strap_min > 0) ? C_strap_min - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [FLT_W-1:0] FLT_TARGET   = FLT_W'(FLT_N);
  localparam logic [FLT_W-1:0] FLT_ONE      = FLT_W'(1);

  logic [1:0]       ln_meta_q, ln_meta_d;
  logic [1:0]       ln_sync_q, ln_sync_d;
  logic [1:0]       pair_s;
  logic [1:0]       pair_prev_q, pair_prev_d;
  logic [FLT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [1:0]       filt_q, filt_d;
  logic             rst_req, boot_req;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             gpio0_q, gpio0_d;
  logic             boot_mode_q, boot_mode_d;
  logic             busy_q, busy_d;

  // Pairs are packed as {dtr, rts}, active high after inversion of the FTDI lines.
  assign pair_s = ~ln_sync_q;

  always_comb begin
    ln_meta_d   = {ftdi_ndtr, ftdi_nrts};
    ln_sync_d   = ln_meta_q;
    pair_prev_d = pair_s;
    if (pair_s == pair_prev_q) begin
      stable_cnt_d = (stable_cnt_q >= FLT_TARGET) ? stable_cnt_q : stable_cnt_q + FLT_ONE;
    end else begin
      stable_cnt_d = FLT_ONE;
    end
    filt_d = (stable_cnt_d >= FLT_TARGET) ? pair_s : filt_q;
  end

  assign rst_req  = filt_q[0] & ~filt_q[1];
  assign boot_req = filt_q[1] & ~filt_q[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;
    boot_mode_d = boot_mode_q;
    case (state_q)
      ST_POWERUP: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (btn_reset || rst_req) begin
          state_d = ST_RESET_HOLD;
          cnt_d   = RESET_LOAD;
          if (btn_reset) begin
            boot_mode_d = 1'b0;
          end
        end
      end
      ST_RESET_HOLD: begin
        if (btn_reset) begin
          cnt_d       = RESET_LOAD;
          boot_mode_d = 1'b0;
        end else if ((cnt_q == '0) && !rst_req) begin
          if (boot_req) begin
            state_d     = ST_STRAP;
            cnt_d       = STRAP_LOAD;
            boot_mode_d = 1'b1;
          end else begin
            state_d     = ST_RUN;
            boot_mode_d = 1'b0;
          end
        end
      end
      ST_STRAP: begin
        if (btn_reset || rst_req) begin
          state_d = ST_RESET_HOLD;
          cnt_d   = RESET_LOAD;
          if (btn_reset) begin
            boot_mode_d = 1'b0;
          end
        end else if ((cnt_q == '0) && !boot_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_POWERUP;
        cnt_d   = POWERUP_LOAD;
      end
    endcase
    en_d    = (state_d == ST_RUN) || (state_d == ST_STRAP);
    gpio0_d = (state_d != ST_STRAP);
    busy_d  = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      ln_meta_q    <= 2'b11;
      ln_sync_q    <= 2'b11;
      pair_prev_q  <= 2'b00;
      stable_cnt_q <= '0;
      filt_q       <= 2'b00;
      state_q      <= ST_POWERUP;
      cnt_q        <= POWERUP_LOAD;
      en_q         <= 1'b0;
      gpio0_q      <= 1'b1;
      boot_mode_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      ln_meta_q    <= ln_meta_d;
      ln_sync_q    <= ln_sync_d;
      pair_prev_q  <= pair_prev_d;
      stable_cnt_q <= stable_cnt_d;
      filt_q       <= filt_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      gpio0_q      <= gpio0_d;
      boot_mode_q  <= boot_mode_d;
      busy_q       <= busy_d;
    end
  end

  assign esp_en    = en_q;
  assign esp_gpio0 = gpio0_q;
  assign boot_mode = boot_mode_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Bench for esp32_boot_sequencer: scripted vector table, hand-written timing sequences and
// randomized line/button traffic compared every cycle against a behavioural model.

module tb_esp32_boot_sequencer;

  localparam int PU = 10;
  localparam int FC = 4;
  localparam int RM = 20;
  localparam int SM = 30;

  logic       clk;
  logic       rst;
  logic       ndtr;
  logic       nrts;
  logic       btn;
  logic       esp_en;
  logic       esp_gpio0;
  logic       boot_mode;
  logic       busy;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  esp32_boot_sequencer #(
    .C_powerup_cycles(PU),
    .C_filter_cycles (FC),
    .C_reset_min     (RM),
    .C_strap_min     (SM)
  ) dut (
    .clk_25mhz(clk),
    .rst      (rst),
    .ftdi_ndtr(ndtr),
    .ftdi_nrts(nrts),
    .btn_reset(btn),
    .esp_en   (esp_en),
    .esp_gpio0(esp_gpio0),
    .boot_mode(boot_mode),
    .busy     (busy),
    .state    (state)
  );

  always #20 clk = ~clk;

  // Behavioural model: the state is tracked with the time it was entered; each state has a
  // minimum dwell (POWERUP PU+1 cycles counting entry, RESET_HOLD RM, STRAP SM).
  int         cyc = 0;
  int         m_state = 0;
  int         m_entered = 0;
  logic       m_bm = 1'b0;
  logic [1:0] m_filt = 2'b00;
  logic [1:0] line_q[$];
  logic [1:0] s_hist[$];

  task automatic modelEdge(input logic r, input logic nd, input logic nr, input logic b);
    logic [1:0] s;
    logic       rq;
    logic       bq;
    logic       all_same;
    int         el;
    cyc++;
    if (r) begin
      m_state   = 0;
      m_entered = cyc;
      m_bm      = 1'b0;
      m_filt    = 2'b00;
      s_hist.delete();
      line_q.delete();
      line_q.push_back(2'b00);
      line_q.push_back(2'b00);
      return;
    end
    s = line_q.pop_front();
    line_q.push_back({~nd, ~nr});
    rq = (m_filt == 2'b01);
    bq = (m_filt == 2'b10);
    el = cyc - m_entered;
    case (m_state)
      0: if (el >= PU + 1) m_state = 1;
      1: if (b || rq) begin
           m_state = 2; m_entered = cyc;
           if (b) m_bm = 1'b0;
         end
      2: if (b) begin
           m_entered = cyc; m_bm = 1'b0;
         end else if (el >= RM && !rq) begin
           if (bq) begin
             m_state = 3; m_entered = cyc; m_bm = 1'b1;
           end else begin
             m_state = 1; m_bm = 1'b0;
           end
         end
      3: if (b || rq) begin
           m_state = 2; m_entered = cyc;
           if (b) m_bm = 1'b0;
         end else if (el >= SM && !bq) begin
           m_state = 1;
         end
      default: m_state = 0;
    endcase
    s_hist.push_back(s);
    if (s_hist.size() > FC) s_hist.delete(0);
    if (s_hist.size() == FC) begin
      all_same = 1'b1;
      foreach (s_hist[i]) if (s_hist[i] != s) all_same = 1'b0;
      if (all_same) m_filt = s;
    end
  endtask

  task automatic checkOutput(input string name, input logic e_en, input logic e_g,
                             input logic e_bm, input logic [2:0] e_st);
    logic e_busy;
    e_busy = (e_st != 3'd1);
    checks++;
    if ({esp_en, esp_gpio0, boot_mode, busy, state} !== {e_en, e_g, e_bm, e_busy, e_st}) begin
      errors++;
      $display("[TB] FAIL %s: got en=%b gpio0=%b boot_mode=%b busy=%b state=%0d, expected en=%b gpio0=%b boot_mode=%b busy=%b state=%0d",
               name, esp_en, esp_gpio0, boot_mode, busy, state, e_en, e_g, e_bm, e_busy, e_st);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAtLeast(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected at least %0d", name, act, min);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare just after.
  task automatic applyStimulus(input logic r, input logic nd, input logic nr, input logic b);
    rst  = r;
    ndtr = nd;
    nrts = nr;
    btn  = b;
    @(posedge clk);
    modelEdge(r, nd, nr, b);
    #1;
    checkOutput($sformatf("model@%0d", cyc), (m_state == 1) || (m_state == 3),
                (m_state != 3), m_bm, 3'(m_state));
  endtask

  typedef struct {
    logic       r;
    logic       nd;
    logic       nr;
    logic       b;
    int         hold;
    logic       en;
    logic       g;
    logic       bm;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int n;
    int m;
    clk  = 1'b0;
    rst  = 1'b0;
    ndtr = 1'b1;
    nrts = 1'b1;
    btn  = 1'b0;
    line_q.push_back(2'b00);
    line_q.push_back(2'b00);

    //             rst   ndtr  nrts  btn  hold en    gpio0 bm    state
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 3'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 20, 1'b1, 1'b1, 1'b0, 3'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 100,1'b1, 1'b1, 1'b0, 3'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b0, 3'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6,  1'b1, 1'b1, 1'b0, 3'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 3'd2};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 40, 1'b0, 1'b1, 1'b0, 3'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6,  1'b0, 1'b1, 1'b0, 3'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 3'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 60, 1'b1, 1'b0, 1'b1, 3'd3};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 6,  1'b1, 1'b0, 1'b1, 3'd3};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b1, 3'd1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b0, 3'd2};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 19, 1'b0, 1'b1, 1'b0, 3'd2};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 3'd1};

    for (int i = 0; i < 17; i++) begin
      for (int h = 0; h < vecs[i].hold; h++) applyStimulus(vecs[i].r, vecs[i].nd, vecs[i].nr, vecs[i].b);
      checkOutput($sformatf("vec%0d", i), vecs[i].en, vecs[i].g, vecs[i].bm, vecs[i].st);
    end

    // RTS glitch shorter than the filter, then a pulse just long enough to be accepted.
    n = 0;
    repeat (3) begin applyStimulus(1'b0, 1'b1, 1'b0, 1'b0); if (!esp_en) n++; end
    repeat (20) begin applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); if (!esp_en) n++; end
    checkValue("glitch_en_low", n, 0);
    n = 0;
    repeat (5) begin applyStimulus(1'b0, 1'b1, 1'b0, 1'b0); if (!esp_en) n++; end
    repeat (60) begin applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); if (!esp_en) n++; end
    checkValue("pulse_en_low", n, RM);
    checkOutput("pulse_end", 1'b1, 1'b1, 1'b0, 3'd1);

    // esptool bootloader entry: RTS, then DTR, then idle.
    n = 0;
    m = 0;
    repeat (50) begin applyStimulus(1'b0, 1'b1, 1'b0, 1'b0); if (!esp_en) n++; if (esp_en && !esp_gpio0) m++; end
    repeat (50) begin applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); if (!esp_en) n++; if (esp_en && !esp_gpio0) m++; end
    repeat (20) begin applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); if (!esp_en) n++; if (esp_en && !esp_gpio0) m++; end
    checkAtLeast("esptool_en_low", n, RM);
    checkAtLeast("esptool_strap", m, SM);
    checkOutput("esptool_end", 1'b1, 1'b1, 1'b1, 3'd1);

    // rst in the middle of RESET_HOLD, with boot_mode still set from the bootloader entry.
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rh_before_rst", 1'b0, 1'b1, 1'b1, 3'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_mid_hold", 1'b0, 1'b1, 1'b0, 3'd0);
    repeat (11) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("powerup_after_rst", 1'b1, 1'b1, 1'b0, 3'd1);

    // Button during STRAP aborts bootloader entry.
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("strap_entered", 1'b1, 1'b0, 1'b1, 3'd3);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("btn_in_strap", 1'b0, 1'b1, 1'b0, 3'd2);
    n = 1;
    repeat (40) begin applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); if (!esp_en) n++; end
    checkValue("btn_en_low", n, RM);
    checkOutput("btn_end", 1'b1, 1'b1, 1'b0, 3'd1);

    // Randomized line pairs, button presses and occasional rst against the model.
    for (int seg = 0; seg < 150; seg++) begin
      logic [1:0] lines;
      int         hold;
      lines = 2'($urandom_range(0, 3));
      hold  = $urandom_range(1, 40);
      for (int k = 0; k < hold; k++) begin
        logic b;
        logic r;
        b = ($urandom_range(0, 24) == 0);
        r = ($urandom_range(0, 399) == 0);
        applyStimulus(r, lines[1], lines[0], b);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
